// File: rtl/response_collector_if.sv
`default_nettype none
//==============================================================================
// Interface : response_collector_if
// Descriptor, per-port response and reduced-result channels of the collector.
// Rev 1.0
//==============================================================================
interface response_collector_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                  pending_valid;
    logic [NUM_PORTS-1:0]  pending_mask;
    logic [TAG_WIDTH-1:0]  pending_tag;
    logic [PORT_W-1:0]     pending_src_port;
    logic                  pending_ready;

    logic [NUM_PORTS-1:0]  port_resp_valid;
    logic [DATA_WIDTH-1:0] port_resp_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]  port_resp_ready;

    logic                  result_valid;
    logic [DATA_WIDTH-1:0] result_data;
    logic [TAG_WIDTH-1:0]  result_tag;
    logic [PORT_W-1:0]     result_dst_port;
    logic                  result_error;
    logic                  result_ready;

    logic                  busy;

    modport master (
        output pending_valid, pending_mask, pending_tag, pending_src_port,
        input  pending_ready,
        output port_resp_valid, port_resp_data,
        input  port_resp_ready,
        input  result_valid, result_data, result_tag, result_dst_port, result_error,
        output result_ready,
        input  busy
    );

    modport slave (
        input  pending_valid, pending_mask, pending_tag, pending_src_port,
        output pending_ready,
        input  port_resp_valid, port_resp_data,
        output port_resp_ready,
        output result_valid, result_data, result_tag, result_dst_port, result_error,
        input  result_ready,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/response_collector.sv
`default_nettype none
//==============================================================================
// Module : response_collector
// Collects one read response per masked port and returns their wrapped sum.
// Optional feature macro: RC_TIMEOUT_EN (collection timeout, error-flagged).
// Rev 1.0
//==============================================================================
module response_collector #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire                    clk,
    input  wire                    rst_n,
    response_collector_if.slave    bus
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        RC_IDLE    = 2'd0,
        RC_COLLECT = 2'd1,
        RC_RESULT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [NUM_PORTS-1:0]  outstanding_q, outstanding_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [PORT_W-1:0]     dst_q, dst_d;
    logic                  err_q, err_d;

    logic [NUM_PORTS-1:0]  w_accept;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_timeout;

`ifdef RC_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is zero on the first collect cycle because it idles at zero elsewhere.
    always_comb begin
        cnt_d = '0;
        if (state_q == RC_COLLECT) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign w_timeout = (cnt_q == CNT_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    assign w_accept = (state_q == RC_COLLECT) ? (bus.port_resp_valid & outstanding_q) : '0;

    // Sum is kept at DATA_WIDTH so overflow wraps naturally.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_accept[i]) w_sum = w_sum + bus.port_resp_data[i];
        end
    end

    always_comb begin
        state_d             = state_q;
        acc_d               = acc_q;
        outstanding_d       = outstanding_q;
        tag_d               = tag_q;
        dst_d               = dst_q;
        err_d               = err_q;
        bus.pending_ready   = 1'b0;
        bus.port_resp_ready = '0;
        bus.result_valid    = 1'b0;
        case (state_q)
            RC_IDLE: begin
                bus.pending_ready = 1'b1;
                if (bus.pending_valid) begin
                    tag_d         = bus.pending_tag;
                    dst_d         = bus.pending_src_port;
                    outstanding_d = bus.pending_mask;
                    acc_d         = '0;
                    err_d         = 1'b0;
                    state_d       = (bus.pending_mask == '0) ? RC_RESULT : RC_COLLECT;
                end
            end
            RC_COLLECT: begin
                bus.port_resp_ready = outstanding_q;
                acc_d         = acc_q + w_sum;
                outstanding_d = outstanding_q & ~w_accept;
                if (outstanding_d == '0) begin
                    state_d = RC_RESULT;
                end else if (w_timeout) begin
                    state_d = RC_RESULT;
                    err_d   = 1'b1;
                end
            end
            RC_RESULT: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) state_d = RC_IDLE;
            end
            default: state_d = RC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RC_IDLE;
            acc_q         <= '0;
            outstanding_q <= '0;
            tag_q         <= '0;
            dst_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            outstanding_q <= outstanding_d;
            tag_q         <= tag_d;
            dst_q         <= dst_d;
            err_q         <= err_d;
        end
    end

    assign bus.result_data     = acc_q;
    assign bus.result_tag      = tag_q;
    assign bus.result_dst_port = dst_q;
`ifdef RC_TIMEOUT_EN
    assign bus.result_error    = err_q;
`else
    assign bus.result_error    = 1'b0;
`endif
    assign bus.busy            = (state_q != RC_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_response_collector.sv
`default_nettype none
//==============================================================================
// Module : tb_response_collector
// Directed self-checking bench for response_collector.
// Rev 1.0
//==============================================================================
module tb_response_collector;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    response_collector_if #(.NUM_PORTS(4), .DATA_WIDTH(32), .TAG_WIDTH(8)) bus ();

    response_collector #(
        .NUM_PORTS(4), .DATA_WIDTH(32), .TAG_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_resp();
        bus.port_resp_valid = '0;
        for (int i = 0; i < 4; i++) bus.port_resp_data[i] = '0;
    endtask

    task automatic send_desc(input logic [3:0] mask, input logic [7:0] tag, input logic [1:0] src);
        bus.pending_valid    = 1'b1;
        bus.pending_mask     = mask;
        bus.pending_tag      = tag;
        bus.pending_src_port = src;
        tick();
        bus.pending_valid    = 1'b0;
        bus.pending_mask     = '0;
        bus.pending_tag      = '0;
        bus.pending_src_port = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.pending_valid    = 1'b0;
        bus.pending_mask     = '0;
        bus.pending_tag      = '0;
        bus.pending_src_port = '0;
        bus.result_ready     = 1'b0;
        clear_resp();

        // Reset values
        #22;
        chk("rst_pending_ready", 64'(bus.pending_ready), 64'd1);
        chk("rst_result_valid",  64'(bus.result_valid), 64'd0);
        chk("rst_resp_ready",    64'(bus.port_resp_ready), 64'd0);
        chk("rst_busy",          64'(bus.busy), 64'd0);
        chk("rst_error",         64'(bus.result_error), 64'd0);
        chk("rst_data",          64'(bus.result_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single transaction, all responses in one cycle; port 2 is not in the mask
        send_desc(4'b1011, 8'h5A, 2'd2);
        chk("t1_busy",          64'(bus.busy), 64'd1);
        chk("t1_pending_ready", 64'(bus.pending_ready), 64'd0);
        chk("t1_resp_ready",    64'(bus.port_resp_ready), 64'b1011);
        bus.port_resp_valid   = 4'b1111;
        bus.port_resp_data[0] = 32'd10;
        bus.port_resp_data[1] = 32'd20;
        bus.port_resp_data[2] = 32'd1000;
        bus.port_resp_data[3] = 32'd30;
        tick();
        clear_resp();
        chk("t1_valid", 64'(bus.result_valid), 64'd1);
        chk("t1_data",  64'(bus.result_data), 64'd60);
        chk("t1_tag",   64'(bus.result_tag), 64'h5A);
        chk("t1_dst",   64'(bus.result_dst_port), 64'd2);
        chk("t1_error", 64'(bus.result_error), 64'd0);
        chk("t1_resp_ready_result", 64'(bus.port_resp_ready), 64'd0);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        chk("t1_release_valid", 64'(bus.result_valid), 64'd0);
        chk("t1_release_pready", 64'(bus.pending_ready), 64'd1);
        chk("t1_release_busy",  64'(bus.busy), 64'd0);

        // Staggered responses with result backpressure
        send_desc(4'b1111, 8'h11, 2'd1);
        bus.port_resp_valid = 4'b0001; bus.port_resp_data[0] = 32'd1;
        tick();
        chk("t2_ready_after_p0", 64'(bus.port_resp_ready), 64'b1110);
        bus.port_resp_valid = 4'b0010; bus.port_resp_data[1] = 32'd2;
        tick();
        bus.port_resp_valid = 4'b0100; bus.port_resp_data[2] = 32'd3;
        tick();
        chk("t2_not_done_valid", 64'(bus.result_valid), 64'd0);
        chk("t2_ready_last",     64'(bus.port_resp_ready), 64'b1000);
        bus.port_resp_valid = 4'b1000; bus.port_resp_data[3] = 32'd4;
        tick();
        clear_resp();
        for (int k = 0; k < 3; k++) begin
            chk("t2_hold_valid", 64'(bus.result_valid), 64'd1);
            chk("t2_hold_data",  64'(bus.result_data), 64'd10);
            chk("t2_hold_tag",   64'(bus.result_tag), 64'h11);
            tick();
        end
        bus.result_ready = 1'b1;
        chk("t2_final_data", 64'(bus.result_data), 64'd10);
        tick();
        bus.result_ready = 1'b0;
        chk("t2_released", 64'(bus.result_valid), 64'd0);

        // Modular wrap
        send_desc(4'b0011, 8'h33, 2'd0);
        bus.port_resp_valid   = 4'b0011;
        bus.port_resp_data[0] = 32'hFFFF_FFFF;
        bus.port_resp_data[1] = 32'h0000_0002;
        tick();
        clear_resp();
        chk("t3_wrap_valid", 64'(bus.result_valid), 64'd1);
        chk("t3_wrap_data",  64'(bus.result_data), 64'h1);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;

        // Zero mask goes straight to result
        send_desc(4'b0000, 8'h77, 2'd3);
        chk("t3_zero_valid",      64'(bus.result_valid), 64'd1);
        chk("t3_zero_data",       64'(bus.result_data), 64'd0);
        chk("t3_zero_tag",        64'(bus.result_tag), 64'h77);
        chk("t3_zero_dst",        64'(bus.result_dst_port), 64'd3);
        chk("t3_zero_error",      64'(bus.result_error), 64'd0);
        chk("t3_zero_resp_ready", 64'(bus.port_resp_ready), 64'd0);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;

        // Asynchronous reset mid-collect
        send_desc(4'b1111, 8'h22, 2'd1);
        bus.port_resp_valid = 4'b0001; bus.port_resp_data[0] = 32'd5;
        tick();
        clear_resp();
        chk("t4_pre_rst_ready", 64'(bus.port_resp_ready), 64'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy",   64'(bus.busy), 64'd0);
        chk("t4_rst_pready", 64'(bus.pending_ready), 64'd1);
        chk("t4_rst_rready", 64'(bus.port_resp_ready), 64'd0);
        chk("t4_rst_valid",  64'(bus.result_valid), 64'd0);
        chk("t4_rst_tag",    64'(bus.result_tag), 64'd0);
        chk("t4_rst_data",   64'(bus.result_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_desc(4'b0101, 8'h44, 2'd2);
        bus.port_resp_valid   = 4'b0101;
        bus.port_resp_data[0] = 32'd8;
        bus.port_resp_data[2] = 32'd9;
        tick();
        clear_resp();
        chk("t4_new_data", 64'(bus.result_data), 64'd17);
        chk("t4_new_tag",  64'(bus.result_tag), 64'h44);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;

        // Partial collection: timeout with error, or indefinite wait without it
        send_desc(4'b0110, 8'h66, 2'd3);
        bus.port_resp_valid = 4'b0010; bus.port_resp_data[1] = 32'd7;
        tick();
        clear_resp();
        for (int k = 0; k < 14; k++) tick();
        chk("t5_before_limit_valid", 64'(bus.result_valid), 64'd0);
        tick();
`ifdef RC_TIMEOUT_EN
        chk("t5_to_valid", 64'(bus.result_valid), 64'd1);
        chk("t5_to_error", 64'(bus.result_error), 64'd1);
        chk("t5_to_data",  64'(bus.result_data), 64'd7);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        bus.port_resp_valid = 4'b0100; bus.port_resp_data[2] = 32'd3;
        tick();
        chk("t5_late_ignored", 64'(bus.port_resp_ready), 64'd0);
        clear_resp();
`else
        for (int k = 0; k < 20; k++) tick();
        chk("t5_wait_busy",  64'(bus.busy), 64'd1);
        chk("t5_wait_valid", 64'(bus.result_valid), 64'd0);
        chk("t5_wait_ready", 64'(bus.port_resp_ready), 64'b0100);
        bus.port_resp_valid = 4'b0100; bus.port_resp_data[2] = 32'd3;
        tick();
        clear_resp();
        chk("t5_done_valid", 64'(bus.result_valid), 64'd1);
        chk("t5_done_data",  64'(bus.result_data), 64'd10);
        chk("t5_done_error", 64'(bus.result_error), 64'd0);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
`endif
        chk("end_idle", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/response_collector.md
Name: response_collector

Overview:
Downstream companion of the read requester in the LOAD_REDUCE path. Accepts one pending-read descriptor (node mask, tag, source port), then collects one read response from each masked port. It sums the response data modulo 2^DATA_WIDTH and presents a single reduced result, tagged for return to the original requester. One transaction is in flight at a time.

Parameters:
NUM_PORTS, 4, number of switch ports / response channels
DATA_WIDTH, 32, width of read response data and reduced result
TAG_WIDTH, 8, request tag width
TIMEOUT_CYCLES, 1024, collection timeout in cycles (used only with RC_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
pending_valid  input  1  descriptor valid from read requester
pending_mask  input  NUM_PORTS  ports whose responses are expected
pending_tag  input  TAG_WIDTH  request tag
pending_src_port  input  $clog2(NUM_PORTS)  original requester port
pending_ready  output  1  descriptor accepted when high with pending_valid
port_resp_valid  input  NUM_PORTS  per-port read response valid
port_resp_data  input  DATA_WIDTH x NUM_PORTS  unpacked array, per-port response data
port_resp_ready  output  NUM_PORTS  per-port response accept
result_valid  output  1  reduced result valid
result_data  output  DATA_WIDTH  sum of collected responses
result_tag  output  TAG_WIDTH  copy of pending_tag
result_dst_port  output  $clog2(NUM_PORTS)  copy of pending_src_port
result_error  output  1  result produced by timeout (constant 0 without RC_TIMEOUT_EN)
result_ready  input  1  consumer accepts result
busy  output  1  state != RC_IDLE

Behaviour:
- Reset: state RC_IDLE. Accumulator, outstanding mask, tag and dst registers are 0. Every output is 0 except pending_ready, which is 1.
- States: RC_IDLE, RC_COLLECT, RC_RESULT.
- RC_IDLE: pending_ready=1.
  - On pending_valid: latch tag/src_port, set outstanding=pending_mask, acc=0.
  - Next state is RC_COLLECT, or RC_RESULT if pending_mask==0; a zero mask yields result_data=0 and result_error=0.
- RC_COLLECT: port_resp_ready[i] = outstanding[i]. Responses from non-outstanding ports are not accepted; they stall on that port.
  - Each cycle: acc <= acc + sum of port_resp_data[i] over every i with valid&ready. Any number of ports may complete in the same cycle.
  - Clear the outstanding bits of accepted ports.
  - When the update leaves outstanding==0, go to RC_RESULT next cycle.
- Latency: last response accepted in cycle M gives result_valid=1 in cycle M+1. A descriptor accepted at N with all responses valid at N+1 gives result at N+2.
- RC_RESULT: result_valid=1; data/tag/dst/error are held stable until result_ready.
  - On result_valid&result_ready, go to RC_IDLE. pending_ready rises the following cycle; there is no same-cycle back-to-back.
- Arithmetic: unsigned, wraps modulo 2^DATA_WIDTH. The internal sum may be widened, but only the low DATA_WIDTH bits are kept.
- pending_ready and port_resp_ready are 0 outside the states listed above.
- Asynchronous reset mid-transaction abandons the transaction. All state clears; partially collected data is lost.

Optional Feature:
RC_TIMEOUT_EN:
- Defined: a cycle counter clears on entry to RC_COLLECT and increments each RC_COLLECT cycle.
  - If it reaches TIMEOUT_CYCLES-1 with outstanding!=0, go to RC_RESULT with result_error=1 and result_data=partial acc.
  - Responses accepted in that final cycle are included.
  - Late responses for the abandoned transaction are not accepted while idle.
- Undefined: no counter; RC_COLLECT waits indefinitely; result_error tied 0.

Test Plan:
- Reset: hold rst_n=0 → pending_ready=1, result_valid=0, port_resp_ready=0, busy=0, result_error=0.
- Single transaction: mask=4'b1011, tag=8'h5A, src=2; responses 10,20,30 on ports 0,1,3 in the same cycle → result_valid next cycle, data=60, tag=8'h5A, dst=2, error=0.
- Staggered responses with backpressure: mask=4'b1111; data 1,2,3,4 arrive on separate cycles; result_ready held low 3 cycles → data=10 stable throughout; a port already responded has port_resp_ready=0; result releases on ready.
- Wrap and zero mask: mask=4'b0011, data 32'hFFFFFFFF and 32'h2 → result 32'h1. Then mask=0 → result data=0 without any response handshake.
- Reset mid-collect: mask=4'b1111, only port 0 responds, assert rst_n=0 → all outputs return to reset values. A new transaction then sums correctly from 0.
- RC_TIMEOUT_EN defined, TIMEOUT_CYCLES=16: mask=4'b0110, only port 1 responds with 7 → after 16 collect cycles, result_valid=1, error=1, data=7.
